// File: rtl/p251_mul_arb_pkg.sv
// p251_mul_arb_pkg: shared state encoding and index-width helpers for the multiplier arbiter
package p251_mul_arb_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t ISSUE = 2'd1;
  localparam state_t WAIT = 2'd2;
  localparam state_t RESP = 2'd3;
  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 8;
  localparam int IDX_W = $clog2(DEF_N_REQ);
  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/p251_mul_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search for the first set request at or after ptr
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);
  logic [IDX_W-1:0] c;
  // scan from farthest to nearest so the candidate closest to ptr wins
  always_comb begin
    found = |req;
    idx = '0;
    c = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      c = IDX_W'((int'(ptr) + k) % N_REQ);
      idx = req[c] ? c : idx;
    end
  end
endmodule

// File: rtl/p251_mul_arbiter.sv
// p251_mul_arbiter: round-robin sharing of one multi-cycle field multiplier among N_REQ requesters
module p251_mul_arbiter
  import p251_mul_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_in_1,
  input  logic [N_REQ*WIDTH-1:0] req_in_2,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]       resp_out,
  output logic                   busy,
  output logic                   mul_start,
  output logic [WIDTH-1:0]       mul_in_1,
  output logic [WIDTH-1:0]       mul_in_2,
  input  logic [WIDTH-1:0]       mul_out,
  input  logic                   mul_done
);
  localparam int IW = idx_w(N_REQ);
  state_t state;
  logic [IW-1:0] ptr, owner, idx;
  logic found;
  rr_pick #(.N_REQ(N_REQ), .IDX_W(IW)) u_pick (
    .req(req),
    .ptr(ptr),
    .found(found),
    .idx(idx)
  );
  assign busy = state != IDLE;
  // sequencer: accept one request, pulse start/grant, wait for done, pulse the response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      grant <= '0;
      resp_valid <= '0;
      resp_out <= '0;
      mul_start <= 1'b0;
      mul_in_1 <= '0;
      mul_in_2 <= '0;
    end else begin
      grant <= '0;
      resp_valid <= '0;
      mul_start <= 1'b0;
      case (state)
        IDLE: if (found) begin
          owner <= idx;
          mul_in_1 <= req_in_1[int'(idx)*WIDTH +: WIDTH];
          mul_in_2 <= req_in_2[int'(idx)*WIDTH +: WIDTH];
          grant <= N_REQ'(1) << idx;
          mul_start <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: state <= WAIT;
        WAIT: if (mul_done) begin
          resp_out <= mul_out;
          resp_valid <= N_REQ'(1) << owner;
          state <= RESP;
        end
        RESP: begin
          ptr <= (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/p251_mul_arbiter.md
# p251_mul_arbiter

Round-robin scheduler that shares one multi-cycle field multiplier (p251_mul or gf_mul, same start/done interface) among N_REQ requesters. It accepts one request at a time, drives the multiplier's start pulse and operands, waits for done, and returns the product to the owning requester with a one-cycle valid pulse. It sits between the SDitH arithmetic engines and a single shared multiplier instance to save area.

## Interface
- N_REQ, 4, number of requesters (2..16)
- WIDTH, 8, operand/result width
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  N_REQ  per-requester request level
- req_in_1  in  N_REQ*WIDTH  operand 1, requester i at bits [i*WIDTH +: WIDTH]
- req_in_2  in  N_REQ*WIDTH  operand 2, same packing
- grant  out  N_REQ  one-hot, one-cycle pulse: request accepted
- resp_valid  out  N_REQ  one-hot, one-cycle pulse: result ready
- resp_out  out  WIDTH  product, valid while any resp_valid bit is high
- busy  out  1  high in every state except IDLE
- mul_start  out  1  one-cycle start pulse to multiplier
- mul_in_1  out  WIDTH  operand 1 to multiplier
- mul_in_2  out  WIDTH  operand 2 to multiplier
- mul_out  in  WIDTH  multiplier result
- mul_done  in  1  multiplier completion pulse

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req bit is set, select the owner by round-robin search starting at pointer ptr (ptr, ptr+1, ... wrapping N_REQ-1 -> 0); latch owner index and its two operands into mul_in_1/mul_in_2; go to ISSUE. If no req, stay.
- ISSUE: grant[owner]=1 and mul_start=1 for exactly this cycle; go to WAIT.
- WAIT: hold mul_in_1/mul_in_2 stable; on mul_done latch mul_out into resp_out; go to RESP.
- RESP: resp_valid[owner]=1 for exactly this cycle; ptr <= owner+1 modulo N_REQ; go to IDLE.
- req is sampled only in IDLE. A requester must hold req and operands until it sees grant, and must drop req in the grant cycle unless it wants a further multiplication with the same or new operands.
- mul_done outside WAIT is ignored; the multiplier latency must be >= 1 cycle after mul_start.
- Fairness: with all requesters asserting continuously, grants rotate 0,1,...,N_REQ-1,0,...
- Reset (asynchronous, any state): state IDLE, ptr 0, owner 0, grant 0, resp_valid 0, resp_out 0, mul_start 0, mul_in_1/mul_in_2 0, busy 0. An in-flight multiplication is abandoned; its late mul_done arrives in IDLE and is ignored.

## Timing
- req sampled high at edge t in IDLE -> grant and mul_start high in cycle t+1 (ISSUE).
- mul_done high in cycle d (d >= t+2) -> resp_valid and resp_out in cycle d+1.
- Total request-to-response latency: multiplier latency L + 2 cycles; back-to-back issue interval L + 3 cycles (next request is sampled in the first IDLE cycle after RESP).
- grant, resp_valid and mul_start are registered outputs, never combinational from inputs.
- resp_out holds its value after RESP until the next mul_done is latched.

## Structure
- Package p251_mul_arb_pkg: state enum (IDLE, ISSUE, WAIT, RESP), localparam IDX_W = $clog2(N_REQ).
- Sub-module rr_pick: combinational, inputs req[N_REQ] and ptr[IDX_W], outputs found and idx; reusable by other shared-resource arbiters.
- The multiplier is not instantiated inside; the top-level design connects it, so gf_mul and p251_mul are interchangeable.

## Test plan
- Single request: req[0]=1, operands 1 and 20, p251_mul attached -> grant[0] in the cycle after sampling, resp_valid[0] with resp_out=20.
- Reduction check: req[2] with operands 250 and 250 -> resp_out=1; req[1] with operands 17 and 15 -> resp_out=4.
- Contention: all four req held high from reset release -> grant order 0,1,2,3,0; each resp_valid matches its grant owner; no two grant bits high at once.
- Pointer wrap: after owner 3 completes, only req[1] and req[3] high -> grant[1] first.
- Reset mid-WAIT: assert rst two cycles after mul_start -> all outputs 0 immediately; the late mul_done produces no resp_valid; the next request is served normally with ptr=0.
- Spurious done: pulse mul_done in IDLE and in ISSUE -> no state change, no resp_valid, resp_out unchanged.
